hub_rx: RTL
===========

# hub_rx

Serial receiver for the capture-to-hub link: the hub-side counterpart of the transient signal capture block. It watches the capture block's trigger-ready line (TRD) and requests the buffered samples with SBF. It then deserialises the SD/CD frame into a local 32-byte buffer and exposes that buffer through a registered read port to the rest of the hub. All link inputs are driven on the falling edge of the shared clock and are sampled here on the rising edge.

## Interface
- `DEPTH`, 32: capacity of the receive buffer in bytes; the maximum frame length.
- `CD_TIMEOUT`, 64: clock cycles SBF may stay asserted without CD going low before the request is abandoned.
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `TRD`  in  1  capture block has a completed capture ready.
- `SD`  in  1  serial data; idle high.
- `CD`  in  1  completed-data line; low for the whole frame.
- `SBF`  out  1  send-buffer request to the capture block.
- `busy`  out  1  high from request until the frame ends or is abandoned.
- `done`  out  1  one-cycle pulse when a frame completes cleanly.
- `byte_count`  out  6  bytes stored in the current or last frame (0..DEPTH).
- `frame_err`  out  1  sticky; a start bit was missing or CD rose mid-byte.
- `overflow`  out  1  sticky; the frame exceeded DEPTH bytes.
- `timeout`  out  1  sticky; CD did not fall within CD_TIMEOUT cycles.
- `rd_addr`  in  5  buffer read address.
- `rd_data`  out  8  `buffer[rd_addr]`, registered.

## Operation
- States:
  - IDLE
  - REQ: SBF high, waiting for CD low.
  - HUNT: waiting for the first start bit.
  - DATA: shifting in 8 bits.
  - GAP: the slot where either the next start bit or CD high is expected.
  - FLUSH: discarding until CD high.
- IDLE → REQ: on a TRD rising edge (TRD was low the previous cycle, high this cycle).
- Entering REQ:
  - Clear `byte_count`, `frame_err`, `overflow` and `timeout`.
  - Raise SBF and `busy`.
- REQ:
  - On the first sample with CD=0: drop SBF and go to HUNT.
  - If CD is still high after CD_TIMEOUT cycles: set `timeout`, drop SBF, go to IDLE.
- HUNT: wait while SD=1. Sampling SD=0 is the start bit; go to DATA with the bit counter at 0.
- DATA:
  - Sample SD each cycle, LSB first, 8 samples in total.
  - On the 8th sample, write the byte to `buffer[byte_count]`, increment `byte_count`, and go to GAP.
  - The link has no stop bit; bytes are back to back.
- GAP:
  - CD=1: clean end. Pulse `done`, go to IDLE.
  - CD=0 and SD=0: next start bit. Go to DATA. If `byte_count == DEPTH`, set `overflow` and go to FLUSH instead.
  - CD=0 and SD=1: set `frame_err`, go to FLUSH.
- CD=1 sampled while in DATA: set `frame_err`, go to IDLE. The partial byte is not stored.
- FLUSH: ignore SD and go to IDLE on CD=1. No `done` pulse.
- `busy` is high in every state except IDLE.
- `byte_count` saturates at DEPTH.
- Buffer contents are retained across frames and are only overwritten by new bytes.

## Timing
- Reset values:
  - SBF=0, `busy`=0, `done`=0, `byte_count`=0, all error flags 0, `rd_data`=0.
  - State is IDLE and the TRD edge history is 0.
  - Buffer contents are undefined.
- SBF rises on the cycle after the TRD rising edge is sampled.
- SBF falls on the cycle after CD=0 is first sampled.
- Each byte takes 9 cycles: the start sample plus 8 data samples.
- A byte is visible through the read port 2 cycles after its 8th data bit is sampled: one cycle for the write, one for the registered read.
- `done` pulses exactly one cycle, asserted the cycle after CD=1 is sampled in GAP.
- The timeout counter starts at 0 on REQ entry. `timeout` is set when the counter reaches CD_TIMEOUT.
- A TRD edge outside IDLE is ignored.
- Reset asserted mid-frame returns everything to reset values immediately. SBF must drop asynchronously.

## Structure
- Shared package `hub_pkg`: the state enum, `BITS_PER_BYTE` = 8, default `DEPTH`, and the `byte_count` width derived as `$clog2(DEPTH+1)`.
- Sub-module `hub_rx_buffer`: a DEPTH×8 single-write, registered-read memory (the write port from the FSM, the read port to `rd_addr`/`rd_data`).
- The FSM, shift register, bit counter and timeout counter live in `hub_rx`.

## Test plan
- Clean short frame: TRD pulse, then a 3-byte frame 0xA5, 0x3C, 0xFF → SBF high 1 cycle after TRD until CD falls; `done` pulse; `byte_count`=3; reads at addresses 0..2 return A5/3C/FF; no error flags.
- Full frame: 32 bytes 0x00..0x1F → `byte_count`=32; every address reads back its index; `done` pulses; `overflow`=0.
- Over-length frame: 33 bytes → `overflow`=1; `byte_count`=32; no `done`; return to IDLE after CD rises; `buffer[31]`=0x1F.
- Framing error: SD held high in the start slot after byte 2 → `frame_err`=1; `byte_count`=2; FLUSH until CD high; no `done`.
- CD timeout: TRD rises but CD stays high → after 64 cycles `timeout`=1, SBF=0, `busy`=0; a second TRD edge re-requests and clears `timeout`.
- Reset mid-byte: drop reset after 4 data bits of byte 1 → all outputs at reset values at once; a subsequent clean frame is received correctly.

Source files
------------

// File: rtl/hub_pkg.sv
// Shared definitions for the hub-side capture link receiver.
//   BITS_PER_BYTE : serial bits per byte (LSB first, no stop bit)
//   DEPTH_DEFAULT : default receive buffer capacity in bytes
//   BYTE_CNT_W    : byte_count width for the default depth (0..DEPTH inclusive)
//   hub_state_t   : receiver FSM states
package hub_pkg;

    localparam int unsigned BITS_PER_BYTE = 8;
    localparam int unsigned DEPTH_DEFAULT = 32;
    localparam int unsigned BYTE_CNT_W    = $clog2(DEPTH_DEFAULT + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_HUNT,
        ST_DATA,
        ST_GAP,
        ST_FLUSH
    } hub_state_t;

endpackage

// File: rtl/hub_rx_buffer.sv
// Receive buffer: DEPTH x 8 memory, one write port, registered read port.
//   clk, reset        : clock, async active-low reset (read register only)
//   wr_en/wr_addr/wr_data : write port from the receiver FSM
//   rd_addr / rd_data : read port, rd_data = mem[rd_addr] one cycle later
module hub_rx_buffer
    import hub_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [BITS_PER_BYTE-1:0] wr_data,
    input  logic [AW-1:0]            rd_addr,
    output logic [BITS_PER_BYTE-1:0] rd_data
);

    logic [BITS_PER_BYTE-1:0] mem [DEPTH];

    // Storage is not reset; contents persist across frames.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/hub_rx.sv
// Hub-side receiver for the capture link. Requests the capture buffer on a
// TRD rising edge, deserialises the SD/CD frame into a local buffer and
// exposes it through a registered read port.
//   clk, reset  : clock, async active-low reset
//   TRD         : capture ready (rising edge starts a request)
//   SD, CD      : serial data (idle high), frame-active (low during frame)
//   SBF         : send-buffer request
//   busy, done  : transfer in progress / clean-frame pulse
//   byte_count  : bytes stored in current or last frame
//   frame_err, overflow, timeout : sticky error flags, cleared on request
//   rd_addr, rd_data : buffer read port (registered)
module hub_rx
    import hub_pkg::*;
#(
    parameter int unsigned DEPTH      = DEPTH_DEFAULT,
    parameter int unsigned CD_TIMEOUT = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         TRD,
    input  logic                         SD,
    input  logic                         CD,
    output logic                         SBF,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(DEPTH+1)-1:0]   byte_count,
    output logic                         frame_err,
    output logic                         overflow,
    output logic                         timeout,
    input  logic [$clog2(DEPTH)-1:0]     rd_addr,
    output logic [BITS_PER_BYTE-1:0]     rd_data
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned TO_W  = $clog2(CD_TIMEOUT + 1);
    localparam int unsigned BIT_W = $clog2(BITS_PER_BYTE);
    localparam int unsigned SH_W  = BITS_PER_BYTE - 1;

    hub_state_t               state, state_nxt;
    logic                     trd_q;
    logic                     sbf_nxt, done_nxt;
    logic                     ferr_nxt, ovf_nxt, tmo_nxt;
    logic [CNT_W-1:0]         cnt_nxt;
    logic [SH_W-1:0]          shreg, sh_nxt;
    logic [BIT_W-1:0]         bitcnt, bit_nxt;
    logic [TO_W-1:0]          tcnt, tcnt_nxt;
    logic                     wr_en, wr_en_nxt;
    logic [AW-1:0]            wr_addr, wr_addr_nxt;
    logic [BITS_PER_BYTE-1:0] wr_data, wr_data_nxt;
    logic [BITS_PER_BYTE-1:0] byte_c;

    // State and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            trd_q      <= 1'b0;
            SBF        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            byte_count <= '0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
            timeout    <= 1'b0;
            shreg      <= '0;
            bitcnt     <= '0;
            tcnt       <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            state      <= state_nxt;
            trd_q      <= TRD;
            SBF        <= sbf_nxt;
            busy       <= (state_nxt != ST_IDLE);
            done       <= done_nxt;
            byte_count <= cnt_nxt;
            frame_err  <= ferr_nxt;
            overflow   <= ovf_nxt;
            timeout    <= tmo_nxt;
            shreg      <= sh_nxt;
            bitcnt     <= bit_nxt;
            tcnt       <= tcnt_nxt;
            wr_en      <= wr_en_nxt;
            wr_addr    <= wr_addr_nxt;
            wr_data    <= wr_data_nxt;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_nxt   = state;
        sbf_nxt     = SBF;
        done_nxt    = 1'b0;
        cnt_nxt     = byte_count;
        ferr_nxt    = frame_err;
        ovf_nxt     = overflow;
        tmo_nxt     = timeout;
        sh_nxt      = shreg;
        bit_nxt     = bitcnt;
        tcnt_nxt    = tcnt;
        wr_en_nxt   = 1'b0;
        wr_addr_nxt = wr_addr;
        wr_data_nxt = wr_data;
        // Current sample completes the byte when it is the 8th (LSB first).
        byte_c      = {SD, shreg};

        unique case (state)
            ST_IDLE: begin
                if (TRD && !trd_q) begin
                    state_nxt = ST_REQ;
                    sbf_nxt   = 1'b1;
                    cnt_nxt   = '0;
                    ferr_nxt  = 1'b0;
                    ovf_nxt   = 1'b0;
                    tmo_nxt   = 1'b0;
                    tcnt_nxt  = '0;
                end
            end
            ST_REQ: begin
                if (!CD) begin
                    sbf_nxt   = 1'b0;
                    state_nxt = ST_HUNT;
                end else if (tcnt == TO_W'(CD_TIMEOUT - 1)) begin
                    // This is the CD_TIMEOUT-th high sample since entry.
                    tmo_nxt   = 1'b1;
                    sbf_nxt   = 1'b0;
                    state_nxt = ST_IDLE;
                end else begin
                    tcnt_nxt = tcnt + TO_W'(1);
                end
            end
            ST_HUNT: begin
                if (CD) begin
                    state_nxt = ST_IDLE;
                end else if (!SD) begin
                    bit_nxt   = '0;
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (CD) begin
                    // Partial byte is dropped.
                    ferr_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    sh_nxt  = byte_c[BITS_PER_BYTE-1:1];
                    bit_nxt = bitcnt + BIT_W'(1);
                    if (bitcnt == BIT_W'(BITS_PER_BYTE - 1)) begin
                        wr_en_nxt   = 1'b1;
                        wr_addr_nxt = byte_count[AW-1:0];
                        wr_data_nxt = byte_c;
                        if (byte_count != CNT_W'(DEPTH)) begin
                            cnt_nxt = byte_count + CNT_W'(1);
                        end
                        state_nxt = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (CD) begin
                    done_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (!SD) begin
                    if (byte_count == CNT_W'(DEPTH)) begin
                        ovf_nxt   = 1'b1;
                        state_nxt = ST_FLUSH;
                    end else begin
                        bit_nxt   = '0;
                        state_nxt = ST_DATA;
                    end
                end else begin
                    ferr_nxt  = 1'b1;
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (CD) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    hub_rx_buffer #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_buffer (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule
